datagram_serializer: RTL

//  Downstream of the control core. Snapshots the MESSAGE_SIZE-wide datagram on a send request and streams it to the

---
 rtl/datagram_serializer_pkg.sv | 27 ++
 rtl/datagram_serializer_uart_transmitter.sv | 105 ++++++++++
 rtl/datagram_serializer.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/datagram_serializer_pkg.sv
// Shared link constants and state types for the datagram serializer and its 8N1 byte transmitter.
// The optional checksum trailer is controlled by the DATAGRAM_CHECKSUM_EN macro in datagram_serializer.sv.
package datagram_serializer_pkg;

   localparam int         MESSAGE_SIZE      = 16;
   localparam int         LINK_CLKS_PER_BIT = 868;   // 100 MHz / 115200 baud
   localparam logic [7:0] LINK_SYNC_BYTE    = 8'hA5;

   // Bit-level states of the 8N1 shifter.
   typedef enum logic [1:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_STOP
   } LinkTxState;

   // Frame-level states; the one-cycle DONE phase is the final stop-bit cycle of the last byte.
   typedef enum logic {
      FR_IDLE,
      FR_SEND
   } FrameState;

   function automatic int frame_byte_count(input int nbytes, input int ck);
      return nbytes + 1 + ck;
   endfunction

endpackage

// File: rtl/datagram_serializer_uart_transmitter.sv
// Byte-level 8N1 shifter: start bit, 8 data bits LSB-first, stop bit, each CLKS_PER_BIT cycles.
// ready is high when idle and in the final stop-bit cycle, so bytes can be chained with no gap.
module uart_transmitter
   import datagram_serializer_pkg::*;
#(
   parameter int CLKS_PER_BIT = LINK_CLKS_PER_BIT
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] data,
   output logic       ready,
   output logic       TxD
);

   localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

   LinkTxState      state_reg, state_next;
   logic [BW-1:0]   baud_reg, baud_next;
   logic [2:0]      bit_reg, bit_next;
   logic [7:0]      shift_reg, shift_next;
   logic            txd_reg, txd_next;
   logic            baud_last;

   assign baud_last = (baud_reg == BW'(CLKS_PER_BIT - 1));
   assign ready     = (state_reg == TX_IDLE) || ((state_reg == TX_STOP) && baud_last);
   assign TxD       = txd_reg;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= TX_IDLE;
         baud_reg  <= '0;
         bit_reg   <= '0;
         shift_reg <= '0;
         txd_reg   <= 1'b1;
      end else begin
         state_reg <= state_next;
         baud_reg  <= baud_next;
         bit_reg   <= bit_next;
         shift_reg <= shift_next;
         txd_reg   <= txd_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      baud_next  = baud_reg;
      bit_next   = bit_reg;
      shift_next = shift_reg;
      txd_next   = txd_reg;

      case (state_reg)
         TX_IDLE: begin
            txd_next = 1'b1;
         end
         TX_START: begin
            if (baud_last) begin
               baud_next  = '0;
               bit_next   = '0;
               txd_next   = shift_reg[0];
               state_next = TX_DATA;
            end else begin
               baud_next = baud_reg + BW'(1);
            end
         end
         TX_DATA: begin
            if (baud_last) begin
               baud_next = '0;
               if (bit_reg == 3'd7) begin
                  txd_next   = 1'b1;
                  state_next = TX_STOP;
               end else begin
                  bit_next   = bit_reg + 3'd1;
                  shift_next = {1'b0, shift_reg[7:1]};
                  txd_next   = shift_reg[1];
               end
            end else begin
               baud_next = baud_reg + BW'(1);
            end
         end
         TX_STOP: begin
            if (baud_last) begin
               baud_next  = '0;
               state_next = TX_IDLE;
            end else begin
               baud_next = baud_reg + BW'(1);
            end
         end
         default: begin
            state_next = TX_IDLE;
            txd_next   = 1'b1;
         end
      endcase

      // A new byte in the last stop cycle starts its start bit on the very next edge.
      if (start && ready) begin
         state_next = TX_START;
         baud_next  = '0;
         bit_next   = '0;
         shift_next = data;
         txd_next   = 1'b0;
      end
   end

endmodule

// File: rtl/datagram_serializer.sv
// Snapshots a datagram on send and streams SYNC, payload bytes LSB-first and, when DATAGRAM_CHECKSUM_EN
// is defined, a trailing mod-256 payload sum, as back-to-back 8N1 bytes. Also counts rejected sends.
module datagram_serializer
   import datagram_serializer_pkg::*;
#(
   parameter int         MSG_BITS     = MESSAGE_SIZE,
   parameter int         CLKS_PER_BIT = LINK_CLKS_PER_BIT,
   parameter logic [7:0] SYNC_BYTE    = LINK_SYNC_BYTE
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [MSG_BITS-1:0] datagram,
   input  logic                send,
   output logic                busy,
   output logic                frame_done,
   output logic [7:0]          overrun_cnt,
   output logic                TxD
);

   localparam int NBYTES = (MSG_BITS + 7) / 8;
   localparam int SNAP_W = NBYTES * 8;
`ifdef DATAGRAM_CHECKSUM_EN
   localparam int CK = 1;
`else
   localparam int CK = 0;
`endif
   localparam int NTOT = frame_byte_count(NBYTES, CK);
   localparam int BIW  = $clog2(NBYTES + 3);

   FrameState        state_reg, state_next;
   logic [SNAP_W-1:0] snap_reg, snap_next;
   logic [BIW-1:0]   byte_idx_reg, byte_idx_next;
   logic [7:0]       overrun_reg, overrun_next;
`ifdef DATAGRAM_CHECKSUM_EN
   logic [7:0]       csum_reg, csum_next;
`endif
   logic [7:0]       payload_byte [NBYTES];
   logic [7:0]       pay_sel;
   logic [BIW-1:0]   pidx;
   logic             tx_start, tx_ready, all_sent, accept;
   logic [7:0]       tx_data;

   genvar gi;
   generate
      for (gi = 0; gi < NBYTES; gi++) begin : g_payload
         assign payload_byte[gi] = snap_reg[gi*8 +: 8];
      end
   endgenerate

   // byte_idx counts bytes handed to the shifter; SYNC is byte 0.
   assign pidx        = byte_idx_reg - BIW'(1);
   assign all_sent    = (byte_idx_reg == BIW'(NTOT));
   assign frame_done  = (state_reg == FR_SEND) && all_sent && tx_ready;
   assign busy        = (state_reg == FR_SEND) && !frame_done;
   assign accept      = send && !busy;
   assign overrun_cnt = overrun_reg;

   always_comb begin
      pay_sel = '0;
      for (int i = 0; i < NBYTES; i++) begin
         if (pidx == BIW'(i)) pay_sel = payload_byte[i];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg    <= FR_IDLE;
         snap_reg     <= '0;
         byte_idx_reg <= '0;
         overrun_reg  <= '0;
`ifdef DATAGRAM_CHECKSUM_EN
         csum_reg     <= '0;
`endif
      end else begin
         state_reg    <= state_next;
         snap_reg     <= snap_next;
         byte_idx_reg <= byte_idx_next;
         overrun_reg  <= overrun_next;
`ifdef DATAGRAM_CHECKSUM_EN
         csum_reg     <= csum_next;
`endif
      end
   end

   always_comb begin
      state_next    = state_reg;
      snap_next     = snap_reg;
      byte_idx_next = byte_idx_reg;
      overrun_next  = overrun_reg;
`ifdef DATAGRAM_CHECKSUM_EN
      csum_next     = csum_reg;
`endif
      tx_start      = 1'b0;
      tx_data       = SYNC_BYTE;

      case (state_reg)
         FR_IDLE: begin
         end
         FR_SEND: begin
            if (tx_ready && !all_sent) begin
               tx_start      = 1'b1;
               byte_idx_next = byte_idx_reg + BIW'(1);
`ifdef DATAGRAM_CHECKSUM_EN
               if (byte_idx_reg == BIW'(NBYTES + 1)) begin
                  tx_data = csum_reg;
               end else begin
                  tx_data   = pay_sel;
                  csum_next = csum_reg + pay_sel;
               end
`else
               tx_data = pay_sel;
`endif
            end else if (frame_done) begin
               state_next = FR_IDLE;
            end
         end
         default: state_next = FR_IDLE;
      endcase

      // Accepting in the DONE cycle chains the next frame with no idle bit.
      if (accept) begin
         state_next    = FR_SEND;
         snap_next     = SNAP_W'(datagram);
         byte_idx_next = BIW'(1);
`ifdef DATAGRAM_CHECKSUM_EN
         csum_next     = '0;
`endif
         tx_start      = 1'b1;
         tx_data       = SYNC_BYTE;
      end

      if (send && busy && (overrun_reg != 8'hFF)) overrun_next = overrun_reg + 8'd1;
   end

   uart_transmitter #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_tx (
      .clk  (clk),
      .rst  (rst),
      .start(tx_start),
      .data (tx_data),
      .ready(tx_ready),
      .TxD  (TxD)
   );

endmodule
